// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with optional 2-entry skid buffer, flush and saturating stall counter
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic              in_xfer, out_xfer;
  // with SKID=1 ready comes straight from a flop, cutting the out_ready path
  assign in_ready  = (SKID != 0) ? !skid_v : (!main_v || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (skid_v) begin
      if (out_xfer) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_v || out_ready) begin
        main_d <= in_data;
        main_v <= 1'b1;
      end else begin
        skid_d <= in_data;
        skid_v <= 1'b1;
      end
    end else if (out_xfer) begin
      main_v <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (main_v && !out_ready && !flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table plus scoreboard for skid, no-skid and narrow-counter instances
module tb_pipe_stage_reg;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic a_fl = 1'b0, a_iv = 1'b0, a_or = 1'b0, a_ir, a_ov;
  logic [7:0] a_id = '0, a_od;
  logic [15:0] a_sc;
  logic b_fl = 1'b0, b_iv = 1'b0, b_or = 1'b0, b_ir, b_ov;
  logic [7:0] b_id = '0, b_od;
  logic [15:0] b_sc;
  logic c_fl = 1'b0, c_iv = 1'b0, c_or = 1'b0, c_ir, c_ov;
  logic [7:0] c_id = '0, c_od;
  logic [2:0] c_sc;

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .CNT_W(16)) u_a (.clk(clk), .reset(reset), .flush(a_fl),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .stall_cnt(a_sc));
  pipe_stage_reg #(.DATA_W(8), .SKID(0), .CNT_W(16)) u_b (.clk(clk), .reset(reset), .flush(b_fl),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .stall_cnt(b_sc));
  pipe_stage_reg #(.DATA_W(8), .SKID(1), .CNT_W(3)) u_c (.clk(clk), .reset(reset), .flush(c_fl),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .out_valid(c_ov), .out_ready(c_or),
    .out_data(c_od), .stall_cnt(c_sc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboards: push on accept, pop on emit, cleared by reset/flush
  logic [7:0] qa[$], qb[$];
  always @(negedge clk) begin
    if (reset || a_fl) qa.delete();
    else begin
      if (a_ov && a_or) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_sb_underflow got %0h expected none", a_od);
        end else chk("a_sb_order", a_od, qa.pop_front());
      end
      if (a_iv && a_ir) qa.push_back(a_id);
    end
  end
  always @(negedge clk) begin
    if (reset || b_fl) qb.delete();
    else begin
      if (b_ov && b_or) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_sb_underflow got %0h expected none", b_od);
        end else chk("b_sb_order", b_od, qb.pop_front());
      end
      if (b_iv && b_ir) qb.push_back(b_id);
    end
  end

  typedef struct {
    logic iv; logic [7:0] id; logic ordy; logic fl;
    logic eov; logic [7:0] eod; logic cod; logic eir; logic [15:0] esc;
  } vec_t;
  vec_t vt[15];

  initial begin
    vt[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 16'd0};
    vt[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 16'd0};
    vt[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 16'd0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
    vt[4]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b1, 16'd0};
    vt[5]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 16'd1};
    vt[6]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 16'd2};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 16'd3};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0B, 1'b1, 1'b1, 16'd3};
    vt[9]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b1, 16'd3};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd3};
    vt[11] = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b1, 16'd3};
    vt[12] = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 16'd4};
    vt[13] = '{1'b1, 8'h0D, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'd4};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd4};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", a_ov, 0); chk("rst_od", a_od, 0); chk("rst_sc", a_sc, 0);
    chk("rst_ir_skid", a_ir, 1); chk("rst_ir_noskid", b_ir, 1);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      a_iv = vt[i].iv; a_id = vt[i].id; a_or = vt[i].ordy; a_fl = vt[i].fl;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", i), a_ov, vt[i].eov);
      if (vt[i].cod) chk($sformatf("v%0d_od", i), a_od, vt[i].eod);
      chk($sformatf("v%0d_ir", i), a_ir, vt[i].eir);
      chk($sformatf("v%0d_sc", i), a_sc, vt[i].esc);
    end
    a_iv = 1'b0; a_fl = 1'b0;
    chk("a_sb_drained", qa.size(), 0);

    // SKID=0: ready follows out_ready combinationally, replace without bubble
    b_iv = 1'b1; b_id = 8'h44; b_or = 1'b0;
    @(posedge clk); #1;
    chk("b_ov", b_ov, 1); chk("b_od", b_od, 8'h44); chk("b_ir_lo", b_ir, 0);
    b_or = 1'b1; #1 chk("b_ir_follow_hi", b_ir, 1);
    b_or = 1'b0; #1 chk("b_ir_follow_lo", b_ir, 0);
    b_id = 8'h55; b_or = 1'b1; #1 chk("b_ir_hi", b_ir, 1);
    @(posedge clk); #1;
    chk("b_replace_ov", b_ov, 1); chk("b_replace_od", b_od, 8'h55);
    b_iv = 1'b0;
    @(posedge clk); #1;
    chk("b_drain_ov", b_ov, 0); chk("b_sc", b_sc, 0);

    // CNT_W=3 saturation
    c_iv = 1'b1; c_id = 8'h77; c_or = 1'b0;
    @(posedge clk); #1;
    c_iv = 1'b0;
    chk("c_sc0", c_sc, 0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 3) chk("c_sc3", c_sc, 3);
      if (k == 7) chk("c_sc7", c_sc, 7);
    end
    chk("c_sat", c_sc, 7); chk("c_hold_ov", c_ov, 1); chk("c_hold_od", c_od, 8'h77);
    c_or = 1'b1;
    @(posedge clk); #1;
    chk("c_out_ov", c_ov, 0); chk("c_sat_keep", c_sc, 7);

    // asynchronous reset with A in FULL state
    a_iv = 1'b1; a_id = 8'h5A; a_or = 1'b0;
    @(posedge clk); #1;
    a_id = 8'h5B;
    @(posedge clk); #1;
    a_iv = 1'b0;
    chk("full_ov", a_ov, 1); chk("full_od", a_od, 8'h5A);
    chk("full_ir", a_ir, 0); chk("full_sc", a_sc, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_ov", a_ov, 0); chk("arst_od", a_od, 0);
    chk("arst_sc", a_sc, 0); chk("arst_ir", a_ir, 1); chk("arst_c_sc", c_sc, 0);
    @(negedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ov", a_ov, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register with a valid/ready handshake. It is the generic replacement for the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Callers pack their fields into one DATA_W bus. On top of plain capture it adds backpressure, an optional 2-entry skid buffer that registers the ready path, synchronous flush and a saturating stall-cycle counter.

Parameters:
DATA_W, 32, width of the packed payload bus (>=1)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of stall_cnt (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept; transfer when in_valid && in_ready
in_data  in  DATA_W  upstream payload
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
out_data  out  DATA_W  held payload
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Interface (already decided): reset reset, asynchronous, active-high; clock clk.
- Reset values: out_valid=0, out_data=0, stall_cnt=0, all internal valid bits and data registers=0. in_ready=1 when SKID=1. When SKID=0, in_ready=1 (derived).
- Priority each edge: reset > flush > handshake updates.
- Flush: clears main and skid valid bits and zeroes main and skid data on the next edge. Any input transfer in the flush cycle is discarded. Any output transfer in the flush cycle counts as completed. stall_cnt is not affected by flush.
- Latency: payload accepted at edge N is presented on out_data at N+0 registered, i.e. visible in the cycle after acceptance. Minimum latency is 1 cycle. Throughput is 1 per cycle when out_ready is held high.
- Hold rule: while out_valid && !out_ready, out_valid and out_data stay stable until the transfer or a flush.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On input transfer: main <= in_data, valid <= 1.
  - Else on output transfer: valid <= 0; data holds.
- SKID=1: state is {main_v, skid_v}. Legal states are EMPTY(0,0), ONE(1,0), FULL(1,1).
  - in_ready = !skid_v (register output, no combinational path from out_ready).
  - EMPTY: input transfer -> main, go to ONE.
  - ONE:
    - in transfer + out transfer: main <= in_data, stay ONE.
    - in transfer, no out transfer: skid <= in_data, go to FULL.
    - out transfer only: go to EMPTY.
  - FULL (in_ready=0): out transfer -> main <= skid, skid_v <= 0, go to ONE. Otherwise hold.
  - Ordering is strictly FIFO. No payload is ever dropped or duplicated except by flush.
- stall_cnt: increments by 1 each cycle out_valid && !out_ready && !flush. It saturates at 2^CNT_W-1 (no wrap). It is cleared only by reset.
- Reset asserted mid-transfer: all state clears immediately (asynchronously). Nothing is presented after reset deasserts.
- in_data is ignored when in_valid=0. out_data is don't-care when out_valid=0, but it must be 0 after reset or flush.

Test Plan:
- Reset/idle: assert reset mid-stream with FULL state -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1 the same cycle.
- Streaming: SKID=1, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> the same values appear on out_data in order, each one cycle after acceptance; in_ready stays 1.
- Backpressure/skid: SKID=1, out_ready=0, send 0xA,0xB,0xC -> 0xA held at the output, 0xB in skid, in_ready=0 after the second accept, 0xC not accepted; stall_cnt counts each stalled cycle. Release out_ready -> 0xA,0xB,0xC emerge in order.
- Flush: FULL state with 0xA/0xB, pulse flush with in_valid=1, in_data=0xD -> next cycle out_valid=0, out_data=0, 0xD dropped, in_ready=1; stall_cnt keeps its prior value.
- SKID=0 combinational ready: out_valid=1, toggle out_ready -> in_ready follows out_ready in the same cycle. Simultaneous in/out transfer replaces the payload with no bubble.
- Saturation: CNT_W=3, hold out_valid=1 with out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays at 7.
